// File: rtl/multi_counter_ctrl.sv
// Bank of N counters over a dual-port SRAM: port 0 reads, port 1 writes back.
// Two-stage read-modify-write pipeline with one-deep forwarding; zero-fills the SRAM after reset.
module multi_counter_ctrl #(
  parameter int unsigned N   = 16,
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = $clog2(N),
  parameter int unsigned SAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_id,
  input  logic [DW-1:0] req_delta,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_sat,
  output logic          init_done,
  output logic          mem_en0,
  output logic          mem_wen0,
  output logic [AW-1:0] mem_addr0,
  output logic [DW-1:0] mem_din0,
  input  logic [DW-1:0] mem_dout0,
  output logic          mem_en1,
  output logic          mem_wen1,
  output logic [AW-1:0] mem_addr1,
  output logic [DW-1:0] mem_din1
);

  typedef enum logic {StInit, StRun} state_e;

  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpClr = 2'b10;

  state_e        state_q;
  logic [AW-1:0] ptr_q;

  logic          s1_valid_q;
  logic [1:0]    s1_op_q;
  logic [AW-1:0] s1_id_q;
  logic [DW-1:0] s1_delta_q;

  logic          fwd_valid_q;
  logic [AW-1:0] fwd_id_q;
  logic [DW-1:0] fwd_data_q;

  logic [DW-1:0] cur_val;
  logic [DW:0]   sum;
  logic          ovf;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rsp_val;
  logic          sat_flag;

  // Port 0: read issued in the accept cycle, data returns in stage 1.
  assign mem_en0   = req_valid && req_ready;
  assign mem_wen0  = 1'b0;
  assign mem_addr0 = mem_en0 ? req_id : '0;
  assign mem_din0  = '0;

  always_comb begin
    // Same-cycle port-1 write is invisible to port 0; the forward register covers it.
    cur_val  = (fwd_valid_q && (fwd_id_q == s1_id_q)) ? fwd_data_q : mem_dout0;
    sum      = {1'b0, cur_val} + {1'b0, s1_delta_q};
    ovf      = sum[DW];
    wr_en    = 1'b0;
    wr_data  = cur_val;
    rsp_val  = cur_val;
    sat_flag = 1'b0;
    case (s1_op_q)
      OpAdd: begin
        wr_en    = s1_valid_q;
        sat_flag = ovf;
        wr_data  = (ovf && (SAT != 0)) ? {DW{1'b1}} : sum[DW-1:0];
        rsp_val  = wr_data;
      end
      OpClr: begin
        wr_en   = s1_valid_q;
        wr_data = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en1   = 1'b0;
    mem_wen1  = 1'b0;
    mem_addr1 = '0;
    mem_din1  = '0;
    if (state_q == StInit) begin
      // Gated by rst_n so the SRAM sees no writes while reset is held.
      mem_en1   = rst_n;
      mem_wen1  = rst_n;
      mem_addr1 = ptr_q;
    end else if (wr_en) begin
      mem_en1   = 1'b1;
      mem_wen1  = 1'b1;
      mem_addr1 = s1_id_q;
      mem_din1  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      ptr_q       <= '0;
      init_done   <= 1'b0;
      req_ready   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_id_q     <= '0;
      s1_delta_q  <= '0;
      fwd_valid_q <= 1'b0;
      fwd_id_q    <= '0;
      fwd_data_q  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_sat     <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(N - 1)) begin
            state_q   <= StRun;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase

      s1_valid_q <= mem_en0;
      if (mem_en0) begin
        s1_op_q    <= req_op;
        s1_id_q    <= req_id;
        s1_delta_q <= req_delta;
      end

      fwd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        fwd_id_q   <= s1_id_q;
        fwd_data_q <= wr_data;
      end

      rsp_valid <= s1_valid_q;
      rsp_sat   <= s1_valid_q && sat_flag;
      if (s1_valid_q) begin
        rsp_data <= rsp_val;
      end
    end
  end

endmodule
